// File: rtl/proc_pkg.sv
// Shared constants for the parametrised bus processor: opcodes, step encoding
// and bus-source select indices.
package proc_pkg;

  localparam int unsigned IR_W  = 9;
  localparam int unsigned SEL_W = 10;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_e;

  localparam int unsigned SEL_R0  = 0;
  localparam int unsigned SEL_R1  = 1;
  localparam int unsigned SEL_R2  = 2;
  localparam int unsigned SEL_R3  = 3;
  localparam int unsigned SEL_R4  = 4;
  localparam int unsigned SEL_R5  = 5;
  localparam int unsigned SEL_R6  = 6;
  localparam int unsigned SEL_R7  = 7;
  localparam int unsigned SEL_G   = 8;
  localparam int unsigned SEL_DIN = 9;

endpackage

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder with enable.
module dec3to8 (
  input  logic [2:0] w_i,
  input  logic       en_i,
  output logic [7:0] y_o
);

  always_comb begin
    y_o = '0;
    if (en_i) begin
      y_o[w_i] = 1'b1;
    end
  end

endmodule

// File: rtl/proc_alu.sv
// Combinational ALU: add/sub modulo 2^N, bitwise and/xor; other opcodes give 0.
module proc_alu
  import proc_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [2:0]   op_i,
  output logic [N-1:0] res_o
);

  always_comb begin
    res_o = '0;
    case (op_i)
      OP_ADD:  res_o = a_i + b_i;
      OP_SUB:  res_o = a_i - b_i;
      OP_AND:  res_o = a_i & b_i;
      OP_XOR:  res_o = a_i ^ b_i;
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/regn.sv
// N-bit load-enable register with synchronous active-high reset to RESET_VAL.
module regn #(
  parameter int unsigned N         = 16,
  parameter logic [N-1:0] RESET_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);

  logic [N-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= RESET_VAL;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/proc_param.sv
// Parametrised multicycle processor: eight registers, A and G around an ALU,
// all sharing a single one-hot-selected bus.
module proc_param
  import proc_pkg::*;
#(
  parameter int unsigned  N         = 16,
  parameter logic [N-1:0] RESET_VAL = '0
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic [N-1:0] DIN,
  input  logic         Run,
  output logic         Done,
  output logic [N-1:0] BusWires,
  output logic         Busy
);

  step_e             step_q, step_d;
  logic [IR_W-1:0]   ir_q, ir_d;
  logic              ir_in;
  logic [2:0]        op, rx, ry;
  logic [7:0]        x_dec, y_dec;
  logic [7:0]        r_in;
  logic              a_in, g_in;
  logic [SEL_W-1:0]  sel;
  logic [N-1:0]      r_q [8];
  logic [N-1:0]      a_q, g_q, alu_res;

  assign op = ir_q[8:6];
  assign rx = ir_q[5:3];
  assign ry = ir_q[2:0];

  dec3to8 u_dec_x (.w_i(rx), .en_i(1'b1), .y_o(x_dec));
  dec3to8 u_dec_y (.w_i(ry), .en_i(1'b1), .y_o(y_dec));

  for (genvar i = 0; i < 8; i++) begin : g_regs
    regn #(.N(N), .RESET_VAL(RESET_VAL)) u_r (
      .clk_i(Clock), .rst_i(Resetn), .en_i(r_in[i]), .d_i(BusWires), .q_o(r_q[i])
    );
  end

  regn #(.N(N), .RESET_VAL(RESET_VAL)) u_a (
    .clk_i(Clock), .rst_i(Resetn), .en_i(a_in), .d_i(BusWires), .q_o(a_q)
  );

  regn #(.N(N), .RESET_VAL(RESET_VAL)) u_g (
    .clk_i(Clock), .rst_i(Resetn), .en_i(g_in), .d_i(alu_res), .q_o(g_q)
  );

  proc_alu #(.N(N)) u_alu (.a_i(a_q), .b_i(BusWires), .op_i(op), .res_o(alu_res));

  // Step counter and IR; reset overrides Run and every enable.
  always_ff @(posedge Clock) begin
    if (Resetn) begin
      step_q <= T0;
      ir_q   <= IR_W'(RESET_VAL);
    end else begin
      step_q <= step_d;
      ir_q   <= ir_d;
    end
  end

  assign ir_d = ir_in ? DIN[IR_W-1:0] : ir_q;

  always_comb begin
    step_d = step_q;
    ir_in  = 1'b0;
    r_in   = '0;
    a_in   = 1'b0;
    g_in   = 1'b0;
    sel    = '0;
    Done   = 1'b0;
    case (step_q)
      T0: begin
        if (Run) begin
          ir_in  = 1'b1;
          step_d = T1;
        end
      end
      T1: begin
        case (op)
          OP_MV: begin
            sel    = {2'b00, y_dec};
            r_in   = x_dec;
            Done   = 1'b1;
            step_d = T0;
          end
          OP_MVI: begin
            sel[SEL_DIN] = 1'b1;
            r_in         = x_dec;
            Done         = 1'b1;
            step_d       = T0;
          end
          OP_MVNZ: begin
            sel = {2'b00, y_dec};
            if (g_q != '0) begin
              r_in = x_dec;
            end
            Done   = 1'b1;
            step_d = T0;
          end
          OP_NOP: begin
            Done   = 1'b1;
            step_d = T0;
          end
          default: begin
            sel    = {2'b00, x_dec};
            a_in   = 1'b1;
            step_d = T2;
          end
        endcase
      end
      T2: begin
        sel    = {2'b00, y_dec};
        g_in   = 1'b1;
        step_d = T3;
      end
      T3: begin
        sel[SEL_G] = 1'b1;
        r_in       = x_dec;
        Done       = 1'b1;
        step_d     = T0;
      end
    endcase
  end

  // One-hot bus mux; an empty select leaves the bus at zero.
  always_comb begin
    BusWires = '0;
    for (int i = 0; i < 8; i++) begin
      if (sel[i]) begin
        BusWires = BusWires | r_q[i];
      end
    end
    if (sel[SEL_G]) begin
      BusWires = BusWires | g_q;
    end
    if (sel[SEL_DIN]) begin
      BusWires = BusWires | DIN;
    end
  end

  assign Busy = (step_q != T0);

endmodule
